matmul_mac_scheduler: RTL and testbench
=======================================

MATMUL_MAC_SCHEDULER -- requirements
Module: matmul_mac_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge system clock.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, request to compute C = A x B; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, synchronous cancel of an in-progress computation.
REQ-005 SHALL have port a_flat, input, 32, A0..A3 unsigned bytes; A0 = bits [7:0], row-major order.
REQ-006 SHALL have port b_flat, input, 32, B0..B3 unsigned bytes; same packing as a_flat.
REQ-007 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse when results are updated.
REQ-009 SHALL have port c_flat, output, 64, C00, C01, C10, C11 as 16-bit values; C00 = bits [15:0].
REQ-010 SHALL have port ovf, output, 4, per-element flag, bit0 = C00; set when the true sum exceeds 16 bits.

Function
REQ-011 SHALL share one registered 8x8 unsigned multiplier (1-cycle latency) across all 8 products.
REQ-012 SHALL implement the states IDLE, MAC, DRAIN and DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge, latch a_flat/b_flat, clear all four 17-bit accumulators, enter MAC with step=0, and set busy=1.
REQ-014 SHALL, in MAC step k (0..7), issue element e=k[2:1] (i=e[1], j=e[0]), term t=k[0], A index 2i+t, B index 2t+j.
REQ-015 SHALL add each product into accumulator e one edge after issue (product pipeline stage).
REQ-016 SHALL move from MAC to DRAIN on the edge that issues step 7, from DRAIN to DONE after one cycle, and from DONE to IDLE after one cycle.
REQ-017 SHALL, on the DONE edge, load c_flat with accumulator bits [15:0] and ovf with accumulator bit 16, set done=1, and clear busy.
REQ-018 SHALL assert done exactly 10 edges after the edge that sampled start; done SHALL clear on the following edge.
REQ-019 SHALL ignore start while busy=1; the latched operands SHALL NOT change mid-computation.
REQ-020 SHALL accept start in the cycle done is high, giving back-to-back operation with an 11-cycle period.
REQ-021 SHALL treat abort=1 in MAC, DRAIN or DONE-pending as: go to IDLE next edge, busy=0, no done pulse, c_flat/ovf unchanged.
REQ-022 SHALL give abort priority over start when both are high in IDLE, so nothing is launched.
REQ-023 SHALL hold c_flat/ovf stable between done pulses; inputs SHALL NOT affect them combinationally.

Reset
REQ-024 SHALL, on rst_n low (including mid-operation), immediately force state=IDLE, step=0, busy=0, done=0, c_flat=0, ovf=0, accumulators=0, operand and product registers=0.
REQ-025 SHALL resume normally on the first edge after rst_n deasserts; a start at that edge SHALL be accepted.

Structure
REQ-026 SHALL place the state encoding, NUM_STEPS=8, DONE_LATENCY=10 and ACC_W=17 in shared package mmul_pkg.
REQ-027 SHALL implement the registered multiplier as sub-module mac_mult8 (operands in, 16-bit product out, 1-cycle latency, async reset).

Verification
REQ-028 SHALL cover: A=[1,2,3,4], B=[5,6,7,8], start -> done at edge +10; c_flat={50,43,22,19}; ovf=0.
REQ-029 SHALL cover: all operands 0xFF -> each C = 0xFC02; ovf=4'b1111.
REQ-030 SHALL cover: start pulsed again at edge +3 with different operands -> ignored; results match the first operands; exactly one done pulse.
REQ-031 SHALL cover: abort at edge +5 after a prior result of 19/22/43/50 -> busy falls, no done, c_flat still {50,43,22,19}.
REQ-032 SHALL cover: start held high continuously -> done pulses every 11 cycles with correct results each time.
REQ-033 SHALL cover: rst_n pulsed low at edge +6 -> all outputs 0 asynchronously; a new start after release -> correct result at +10.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply MAC scheduler.
package mmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One issue step per product term: 4 elements x 2 terms.
    localparam int unsigned NUM_STEPS    = 8;
    // Edges from the start-sampling edge to the done pulse.
    localparam int unsigned DONE_LATENCY = 10;
    // 16-bit sum of two 8x8 products plus one carry bit for overflow.
    localparam int unsigned ACC_W        = 17;
    localparam int unsigned STEP_W       = $clog2(NUM_STEPS);

endpackage

// File: rtl/mac_mult8.sv
// Registered 8x8 unsigned multiplier, one cycle of latency.
module mac_mult8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    import mmul_pkg::*;

    // Product register; free-running, consumers qualify it themselves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= 16'(a) * 16'(b);
        end
    end

endmodule

// File: rtl/matmul_mac_scheduler.sv
// 2x2 unsigned matrix multiply C = A x B through one shared registered
// multiplier, with an IDLE/MAC/DRAIN/DONE schedule.
module matmul_mac_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a_flat,
    input  logic [31:0] b_flat,
    output logic        busy,
    output logic        done,
    output logic [63:0] c_flat,
    output logic [3:0]  ovf
);
    import mmul_pkg::*;

    state_t                      state_q, state_d;
    logic [STEP_W-1:0]           step_q;
    logic [31:0]                 a_q, b_q;
    logic                        launch, issue, publish;
    logic [1:0]                  a_idx, b_idx;
    logic [7:0]                  a_op, b_op;
    logic [15:0]                 prod;
    logic                        add_q;
    logic [1:0]                  add_idx_q;
    logic [3:0][ACC_W-1:0]       acc_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge control strobes; abort wins over everything.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        issue   = 1'b0;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_MAC;
                    launch  = 1'b1;
                end
            end
            ST_MAC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    issue = 1'b1;
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                publish = !abort;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Step k selects element e = k[2:1] (i = k[2], j = k[1]) and term t = k[0]:
    // A index 2i+t, B index 2t+j.
    always_comb begin
        a_idx = {step_q[2], step_q[0]};
        b_idx = {step_q[0], step_q[1]};
        a_op  = a_q[{a_idx, 3'b000} +: 8];
        b_op  = b_q[{b_idx, 3'b000} +: 8];
    end

    mac_mult8 u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_op),
        .b     (b_op),
        .p     (prod)
    );

    // Operand latch, step counter and the product-valid pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            step_q    <= '0;
            add_q     <= 1'b0;
            add_idx_q <= '0;
        end else begin
            step_q    <= issue ? step_q + 1'b1 : '0;
            add_q     <= issue;
            add_idx_q <= step_q[2:1];
            if (launch) begin
                a_q <= a_flat;
                b_q <= b_flat;
            end
        end
    end

    // Accumulators: cleared on launch, product added one edge after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (launch) begin
            acc_q <= '0;
        end else if (add_q) begin
            acc_q[add_idx_q] <= acc_q[add_idx_q] + ACC_W'(prod);
        end
    end

    // Registered status and result outputs; results only move on publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            c_flat <= '0;
            ovf    <= '0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= publish;
            if (publish) begin
                c_flat <= {acc_q[3][15:0], acc_q[2][15:0], acc_q[1][15:0], acc_q[0][15:0]};
                ovf    <= {acc_q[3][ACC_W-1], acc_q[2][ACC_W-1], acc_q[1][ACC_W-1], acc_q[0][ACC_W-1]};
            end
        end
    end

endmodule

// File: tb/tb_matmul_mac_scheduler.sv
// Directed bench for matmul_mac_scheduler with a result scoreboard.
module tb_matmul_mac_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic        busy;
    logic        done;
    logic [63:0] c_flat;
    logic [3:0]  ovf;

    typedef struct {
        logic [63:0] c;
        logic [3:0]  o;
        int unsigned launch;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned done_cnt    = 0;
    logic        prev_done   = 1'b0;

    localparam logic [63:0] RES1 = {16'd50, 16'd43, 16'd22, 16'd19};

    matmul_mac_scheduler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .busy   (busy),
        .done   (done),
        .c_flat (c_flat),
        .ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference 2x2 product with 17-bit sums.
    function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [16:0] s;
        logic [63:0] c;
        logic [3:0]  o;
        c = '0;
        o = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 17'(a[8*(2*i) +: 8]) * 17'(b[8*j +: 8])
                  + 17'(a[8*(2*i+1) +: 8]) * 17'(b[8*(2+j) +: 8]);
                c[16*(2*i+j) +: 16] = s[15:0];
                o[2*i+j]            = s[16];
            end
        end
        return {o, c};
    endfunction

    // Scoreboard monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("done_single_cycle", 64'(done), 64'd0);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("c_flat", c_flat, e.c);
                    chk("ovf", 64'(ovf), 64'(e.o));
                    chk("done_latency", 64'(cyc - e.launch), 64'd10);
                end
            end
        end
        prev_done <= rst_n ? done : 1'b0;
    end

    // Drive a one-cycle start at the next edge; optionally expect a result.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [67:0] e, input bit push);
        exp_t x;
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        if (push) begin
            x.c      = e[63:0];
            x.o      = e[67:64];
            x.launch = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ha[3];
        logic [31:0] hb[3];
        int unsigned dc;
        logic [31:0] a1, b1, a3, b3, ff;
        a1 = {8'd4, 8'd3, 8'd2, 8'd1};
        b1 = {8'd8, 8'd7, 8'd6, 8'd5};
        a3 = {8'd6, 8'd7, 8'd8, 8'd9};
        b3 = {8'd2, 8'd3, 8'd4, 8'd5};
        ff = 32'hFFFF_FFFF;
        ha = '{32'h0102_0304, 32'h80FF_0A11, 32'hFFFE_FDFC};
        hb = '{32'h0504_0302, 32'hFF01_7F22, 32'hFCFD_FEFF};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a_flat = '0; b_flat = '0;
        repeat (2) @(negedge clk);
        chk("reset_c_flat", c_flat, 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic product.
        launch(a1, b1, {4'b0000, RES1}, 1'b1);
        chk("busy_after_start", 64'(busy), 64'd1);
        drain("t1_drain");
        a_flat = ff; b_flat = ff;
        repeat (3) @(negedge clk);
        chk("c_flat_stable", c_flat, RES1);

        // Full-scale operands overflow every element.
        launch(ff, ff, {4'b1111, {4{16'hFC02}}}, 1'b1);
        drain("t2_drain");

        // Second start while busy is ignored, operands changed mid-run.
        dc = done_cnt;
        launch(a3, b3, model(a3, b3), 1'b1);
        repeat (2) @(negedge clk);
        a_flat = ff; b_flat = ff; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("t3_drain");
        repeat (12) @(negedge clk);
        chk("t3_one_done", 64'(done_cnt - dc), 64'd1);

        // Abort in MAC keeps the previous result.
        launch(a1, b1, {4'b0000, RES1}, 1'b1);
        drain("t4_prior_drain");
        dc = done_cnt;
        launch(ff, ff, '0, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
        chk("abort_c_flat", c_flat, RES1);
        chk("abort_ovf", 64'(ovf), 64'd0);

        // Abort on the edge that would publish.
        launch(ff, ff, '0, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("late_abort_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("late_abort_no_done", 64'(done_cnt - dc), 64'd0);
        chk("late_abort_c_flat", c_flat, RES1);

        // Abort and start together in IDLE launch nothing.
        a_flat = ff; b_flat = ff; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_start_no_done", 64'(done_cnt - dc), 64'd0);

        // Start held high: back-to-back runs every 11 cycles.
        dc = done_cnt;
        a_flat = ha[0]; b_flat = hb[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t x;
            logic [67:0] m;
            m        = model(ha[k], hb[k]);
            x.c      = m[63:0];
            x.o      = m[67:64];
            x.launch = cyc + 1;
            sb.push_back(x);
            @(negedge clk);
            if (k < 2) begin
                a_flat = ha[k+1]; b_flat = hb[k+1];
                repeat (10) @(negedge clk);
            end else begin
                start = 1'b0;
            end
        end
        drain("held_drain");
        repeat (3) @(negedge clk);
        chk("held_done_count", 64'(done_cnt - dc), 64'd3);

        // Asynchronous reset mid-run, then restart straight after release.
        launch(a3, b3, model(a3, b3), 1'b1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_c_flat", c_flat, 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        launch(a1, b1, {4'b0000, RES1}, 1'b1);
        drain("post_reset_drain");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
